// File: rtl/tictactoe_game.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tictactoe_game                                             |
// | Description : 3x3 tic-tac-toe referee with a machine player Y that       |
// |               answers every accepted X move one clock later.             |
// |               Optional macro BLOQUEIO_EN lets Y block X's open lines.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tictactoe_game (
    input  logic       clock,
    input  logic       reset,
    input  logic [0:8] posicaoX,
    output logic [0:8] posicaoY,
    output logic       vencedor,
    output logic [1:0] ganhador,
    output logic       erro
);

    typedef enum logic [1:0] {
        ESPERA_X = 2'd0,
        JOGA_Y   = 2'd1,
        FIM      = 2'd2
    } state_t;

    localparam logic [1:0] c_G_NONE  = 2'b00;
    localparam logic [1:0] c_G_X     = 2'b01;
    localparam logic [1:0] c_G_Y     = 2'b10;
    localparam logic [1:0] c_G_DRAW  = 2'b11;

    localparam logic [0:8] c_CENTER  = 9'b000010000;
    localparam logic [0:8] c_CORNERS = 9'b101000101;
    localparam logic [0:8] c_EDGES   = 9'b010101010;
    localparam logic [0:8] c_FULL    = 9'b111111111;

    function automatic logic [0:8] line_mask(input logic [2:0] k);
        logic [0:8] m;
        case (k)
            3'd0:    m = 9'b111000000;
            3'd1:    m = 9'b000111000;
            3'd2:    m = 9'b000000111;
            3'd3:    m = 9'b100100100;
            3'd4:    m = 9'b010010010;
            3'd5:    m = 9'b001001001;
            3'd6:    m = 9'b100010001;
            default: m = 9'b001010100;
        endcase
        return m;
    endfunction

    function automatic logic has_line(input logic [0:8] b);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((b & line_mask(3'(k))) == line_mask(3'(k))) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Free cells that would finish a line where the owner already holds two.
    function automatic logic [0:8] completing(input logic [0:8] own, input logic [0:8] free);
        logic [0:8] r;
        logic [0:8] m;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            m = line_mask(3'(k));
            if ($countones(own & m) == 2) begin
                r = r | (free & m);
            end
        end
        return r;
    endfunction

    function automatic logic [0:8] lowest(input logic [0:8] mask);
        logic [0:8] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (mask[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    state_t     r_state,  w_state_n;
    logic [0:8] r_xreg,   w_xreg_n;
    logic [0:8] r_posy,   w_posy_n;
    logic       r_venc,   w_venc_n;
    logic [1:0] r_gan,    w_gan_n;
    logic       r_erro,   w_erro_n;
    logic [0:8] r_rej,    w_rej_n;
    logic       r_rej_vld, w_rej_vld_n;

    logic [0:8] w_new;
    logic       w_cleared;
    logic       w_multi;
    logic       w_overlap;
    logic       w_illegal;
    logic       w_xwin;
    logic       w_xfull;
    logic [0:8] w_free;
    logic [0:8] w_tier_a;
    logic [0:8] w_tier_b;
    logic [0:8] w_pick;
    logic [0:8] w_ynext;

    assign w_new     = posicaoX & ~r_xreg;
    assign w_cleared = |(r_xreg & ~posicaoX);
    assign w_multi   = ($countones(w_new) > 1);
    assign w_overlap = |(w_new & r_posy);
    assign w_illegal = w_cleared | w_multi | w_overlap;
    assign w_xwin    = has_line(posicaoX);
    assign w_xfull   = ((posicaoX | r_posy) == c_FULL);

    // Y reasons only about the accepted X bitmap, never the live input.
    assign w_free    = ~(r_xreg | r_posy);
    assign w_tier_a  = completing(r_posy, w_free);
`ifdef BLOQUEIO_EN
    assign w_tier_b  = completing(r_xreg, w_free);
`else
    assign w_tier_b  = '0;
`endif

    always_comb begin
        w_pick = '0;
        if (|w_tier_a) begin
            w_pick = lowest(w_tier_a);
        end else if (|w_tier_b) begin
            w_pick = lowest(w_tier_b);
        end else if (|(w_free & c_CENTER)) begin
            w_pick = c_CENTER;
        end else if (|(w_free & c_CORNERS)) begin
            w_pick = lowest(w_free & c_CORNERS);
        end else begin
            w_pick = lowest(w_free & c_EDGES);
        end
    end

    assign w_ynext = r_posy | w_pick;

    always_comb begin
        w_state_n   = r_state;
        w_xreg_n    = r_xreg;
        w_posy_n    = r_posy;
        w_venc_n    = r_venc;
        w_gan_n     = r_gan;
        w_erro_n    = 1'b0;
        w_rej_n     = r_rej;
        w_rej_vld_n = r_rej_vld;
        case (r_state)
            ESPERA_X: begin
                if (w_illegal) begin
                    // A held illegal bitmap is reported once, not every cycle.
                    if (!(r_rej_vld && (posicaoX == r_rej))) begin
                        w_erro_n = 1'b1;
                    end
                    w_rej_n     = posicaoX;
                    w_rej_vld_n = 1'b1;
                end else if (w_new == '0) begin
                    w_rej_vld_n = 1'b0;
                end else begin
                    w_rej_vld_n = 1'b0;
                    w_xreg_n    = posicaoX;
                    if (w_xwin) begin
                        w_venc_n  = 1'b1;
                        w_gan_n   = c_G_X;
                        w_state_n = FIM;
                    end else if (w_xfull) begin
                        w_gan_n   = c_G_DRAW;
                        w_state_n = FIM;
                    end else begin
                        w_state_n = JOGA_Y;
                    end
                end
            end
            JOGA_Y: begin
                w_posy_n = w_ynext;
                if (has_line(w_ynext)) begin
                    w_venc_n  = 1'b1;
                    w_gan_n   = c_G_Y;
                    w_state_n = FIM;
                end else if ((w_ynext | r_xreg) == c_FULL) begin
                    w_gan_n   = c_G_DRAW;
                    w_state_n = FIM;
                end else begin
                    w_state_n = ESPERA_X;
                end
            end
            FIM: begin
                w_state_n = FIM;
            end
            default: begin
                w_state_n = ESPERA_X;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ESPERA_X;
            r_xreg    <= '0;
            r_posy    <= '0;
            r_venc    <= 1'b0;
            r_gan     <= c_G_NONE;
            r_erro    <= 1'b0;
            r_rej     <= '0;
            r_rej_vld <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_xreg    <= w_xreg_n;
            r_posy    <= w_posy_n;
            r_venc    <= w_venc_n;
            r_gan     <= w_gan_n;
            r_erro    <= w_erro_n;
            r_rej     <= w_rej_n;
            r_rej_vld <= w_rej_vld_n;
        end
    end

    assign posicaoY = r_posy;
    assign vencedor = r_venc;
    assign ganhador = r_gan;
    assign erro     = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_tictactoe_game.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tictactoe_game                                          |
// | Description : Directed and random games against a cell-level model.      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_tictactoe_game;

    logic       clk;
    logic       rst;
    logic [0:8] px;
    logic [0:8] posicaoY;
    logic       vencedor;
    logic [1:0] ganhador;
    logic       erro;

    int checks = 0;
    int errors = 0;

    tictactoe_game dut (
        .clock    (clk),
        .reset    (rst),
        .posicaoX (px),
        .posicaoY (posicaoY),
        .vencedor (vencedor),
        .ganhador (ganhador),
        .erro     (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int corners [4] = '{0, 2, 6, 8};
    int edges   [4] = '{1, 3, 5, 7};

    // Model: game phase 0 = waiting for X, 1 = Y to move, 2 = over.
    logic [0:8] mx, my, mrej;
    logic       mrejv, mv, merr;
    logic [1:0] mg;
    int         phase;

    function automatic bit m_wins(input logic [0:8] b);
        for (int k = 0; k < 8; k++)
            if (b[lines[k][0]] && b[lines[k][1]] && b[lines[k][2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_completes(input logic [0:8] b, input int c);
        int n;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            if (lines[k][0] == c || lines[k][1] == c || lines[k][2] == c) begin
                for (int j = 0; j < 3; j++)
                    if (lines[k][j] != c && b[lines[k][j]]) n++;
                if (n == 2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_free(input int c);
        return !mx[c] && !my[c];
    endfunction

    function automatic int m_choose();
        for (int c = 0; c < 9; c++) if (m_free(c) && m_completes(my, c)) return c;
`ifdef BLOQUEIO_EN
        for (int c = 0; c < 9; c++) if (m_free(c) && m_completes(mx, c)) return c;
`endif
        if (m_free(4)) return 4;
        for (int i = 0; i < 4; i++) if (m_free(corners[i])) return corners[i];
        for (int i = 0; i < 4; i++) if (m_free(edges[i])) return edges[i];
        return -1;
    endfunction

    task automatic m_reset();
        mx = '0; my = '0; mrej = '0; mrejv = 1'b0;
        mv = 1'b0; mg = 2'b00; merr = 1'b0; phase = 0;
    endtask

    task automatic m_edge(input logic [0:8] v);
        int nnew, c;
        bit cleared, overlap;
        merr = 1'b0;
        if (phase == 0) begin
            cleared = 1'b0; overlap = 1'b0; nnew = 0;
            for (int i = 0; i < 9; i++) begin
                if (mx[i] && !v[i]) cleared = 1'b1;
                if (v[i] && !mx[i]) begin
                    nnew++;
                    if (my[i]) overlap = 1'b1;
                end
            end
            if (cleared || nnew > 1 || overlap) begin
                merr  = !(mrejv && mrej == v);
                mrej  = v;
                mrejv = 1'b1;
            end else if (nnew == 0) begin
                mrejv = 1'b0;
            end else begin
                mrejv = 1'b0;
                mx = v;
                if (m_wins(mx)) begin mv = 1'b1; mg = 2'b01; phase = 2; end
                else if ((mx | my) == 9'h1FF) begin mg = 2'b11; phase = 2; end
                else phase = 1;
            end
        end else if (phase == 1) begin
            c = m_choose();
            if (c >= 0) my[c] = 1'b1;
            if (m_wins(my)) begin mv = 1'b1; mg = 2'b10; phase = 2; end
            else if ((mx | my) == 9'h1FF) begin mg = 2'b11; phase = 2; end
            else phase = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset(); else m_edge(px);
        #1;
        chk("posicaoY", 32'(posicaoY), 32'(my));
        chk("vencedor", 32'(vencedor), 32'(mv));
        chk("ganhador", 32'(ganhador), 32'(mg));
        chk("erro",     32'(erro),     32'(merr));
    endtask

    task automatic do_reset();
        rst = 1'b1; px = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic play(input logic [0:8] v);
        px = v;
        step();
        step();
    endtask

    int         r, a, b;
    logic [0:8] tmp;

    initial begin
        rst = 1'b1; px = '0;
        m_reset();
        step();
        chk("reset_y", 32'(posicaoY), 32'h0);
        chk("reset_g", 32'({vencedor, ganhador, erro}), 32'h0);
        rst = 1'b0;

        // First move and Y win sequence.
        play(9'b100000000);
        chk("first_y", 32'(posicaoY), 32'(9'b000010000));
        chk("first_g", 32'({vencedor, ganhador}), 32'h0);
        play(9'b110000000);
        chk("ywin_y2", 32'(posicaoY), 32'(9'b001010000));
        play(9'b110100000);
        chk("ywin_y", 32'(posicaoY), 32'(9'b001010100));
        chk("ywin_g", 32'({vencedor, ganhador}), 32'(3'b110));

        // X win sequence, with and without blocking.
        do_reset();
        play(9'b100000000);
        play(9'b100000001);
        chk("xwin_y2", 32'(posicaoY), 32'(9'b001010000));
        play(9'b100000101);
`ifdef BLOQUEIO_EN
        chk("xwin_y3", 32'(posicaoY), 32'(9'b001110000));
`else
        chk("xwin_y3", 32'(posicaoY), 32'(9'b011010000));
`endif
        px = 9'b100000111;
        step();
        chk("xwin_g", 32'({vencedor, ganhador}), 32'(3'b101));
        px = 9'b111111111;
        step();
        chk("fim_erro", 32'(erro), 32'h0);
        chk("fim_g", 32'({vencedor, ganhador}), 32'(3'b101));

        // Reset out of game-over, then illegal updates.
        do_reset();
        chk("fim_reset", 32'({posicaoY, vencedor, ganhador, erro}), 32'h0);
        px = 9'b110000000;
        step();
        chk("ill_two", 32'(erro), 32'h1);
        step();
        chk("ill_two_hold", 32'(erro), 32'h0);
        chk("ill_two_y", 32'(posicaoY), 32'h0);
        play(9'b100000000);
        chk("ill_after_y", 32'(posicaoY), 32'(9'b000010000));
        px = 9'b000000000;
        step();
        chk("ill_clear", 32'(erro), 32'h1);
        step();
        px = 9'b100000000;
        step();
        chk("ill_restore", 32'(erro), 32'h0);
        px = 9'b100010000;
        step();
        chk("ill_overlap", 32'(erro), 32'h1);
        chk("ill_overlap_y", 32'(posicaoY), 32'(9'b000010000));

        // Random games.
        for (int g = 0; g < 40; g++) begin
            do_reset();
            for (int cyc = 0; cyc < 80 && phase != 2; cyc++) begin
                if (phase == 0) begin
                    r = int'($urandom_range(9, 0));
                    if (r == 0 && mx != '0) begin
                        do a = int'($urandom_range(8, 0)); while (!mx[a]);
                        tmp = mx; tmp[a] = 1'b0; px = tmp;
                    end else if (r == 1) begin
                        a = int'($urandom_range(8, 0));
                        b = int'($urandom_range(8, 0));
                        tmp = mx; tmp[a] = 1'b1; tmp[b] = 1'b1; px = tmp;
                    end else if (r != 2) begin
                        do a = int'($urandom_range(8, 0)); while (mx[a]);
                        tmp = mx; tmp[a] = 1'b1; px = tmp;
                    end
                end
                step();
            end
            repeat (3) begin
                px = 9'($urandom);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
